// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF-stage fetch sequencer.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_EXC_VECTOR = 32'h0000_0080;
  localparam logic [XLEN-1:0] PC_STEP            = 32'd4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } fetch_state_e;

  // Instruction parked while IF/ID is stalled
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_skid_t;

  // Sequential next PC, wrapping modulo 2^32
  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return XLEN'(pc + PC_STEP);
  endfunction

endpackage

// File: rtl/fetch_redirect_sel.sv
// Priority mux over the redirect sources: exception > branch > jump.
module fetch_redirect_sel
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
  input  logic            i_exc,
  input  logic            i_branch_taken,
  input  logic [XLEN-1:0] i_branch_target,
  input  logic            i_jump,
  input  logic [XLEN-1:0] i_jump_target,
  output logic            o_redir_c,
  output logic [XLEN-1:0] o_tgt_c
);

  always_comb begin
    o_redir_c = i_exc | i_branch_taken | i_jump;
    o_tgt_c   = '0;
    if (i_exc) begin
      o_tgt_c = EXC_VECTOR;
    end else if (i_branch_taken) begin
      o_tgt_c = i_branch_target;
    end else if (i_jump) begin
      o_tgt_c = i_jump_target;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage sequencer: drives the pc register and the imem handshake, merges redirects and stalls.
// Optional FETCH_PERF_EN adds fetch/redirect/stall event counters.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter logic [XLEN-1:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            exc_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic            jump_i,
  input  logic [XLEN-1:0] jump_target_i,
  input  logic [XLEN-1:0] pc_q_i,
  output logic [XLEN-1:0] pc_d_o,
  output logic            pc_en_o,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ready_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            instr_valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o
`ifdef FETCH_PERF_EN
  ,
  output logic [XLEN-1:0] perf_fetch_o,
  output logic [XLEN-1:0] perf_redir_o,
  output logic [XLEN-1:0] perf_stall_o
`endif
);

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  fetch_skid_t     r_skid;
  logic [XLEN-1:0] r_pend;
  logic            w_skid_ld;
  logic            w_pend_ld;
  logic            w_redir;
  logic [XLEN-1:0] w_tgt;

  fetch_redirect_sel #(
    .EXC_VECTOR(EXC_VECTOR)
  ) u_redirect_sel (
    .i_exc          (exc_i),
    .i_branch_taken (branch_taken_i),
    .i_branch_target(branch_target_i),
    .i_jump         (jump_i),
    .i_jump_target  (jump_target_i),
    .o_redir_c      (w_redir),
    .o_tgt_c        (w_tgt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Skid and pending-redirect storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_skid <= '0;
      r_pend <= '0;
    end else begin
      if (w_skid_ld) begin
        r_skid <= '{instr: imem_rdata_i, pc: pc_q_i};
      end
      if (w_pend_ld) begin
        r_pend <= w_tgt;
      end
    end
  end

  // Next state and handshake outputs; everything reads 0 while rst is high
  always_comb begin
    w_state_nxt   = r_state;
    w_skid_ld     = 1'b0;
    w_pend_ld     = 1'b0;
    pc_d_o        = '0;
    pc_en_o       = 1'b0;
    imem_req_o    = 1'b0;
    instr_valid_o = 1'b0;
    instr_o       = '0;
    instr_pc_o    = '0;
    if (!rst) begin
      unique case (r_state)
        BOOT: begin
          pc_d_o      = RESET_PC;
          pc_en_o     = 1'b1;
          w_state_nxt = FETCH;
        end
        FETCH: begin
          imem_req_o = 1'b1;
          if (imem_ready_i) begin
            if (w_redir) begin
              pc_d_o  = w_tgt;
              pc_en_o = 1'b1;
            end else if (!stall_i) begin
              instr_valid_o = 1'b1;
              instr_o       = imem_rdata_i;
              instr_pc_o    = pc_q_i;
              pc_d_o        = pc_next(pc_q_i);
              pc_en_o       = 1'b1;
            end else begin
              w_skid_ld   = 1'b1;
              w_state_nxt = HOLD;
            end
          end else if (w_redir) begin
            w_pend_ld   = 1'b1;
            w_state_nxt = DRAIN;
          end
        end
        DRAIN: begin
          // Address stays put until the stale response arrives and is dropped
          imem_req_o = 1'b1;
          w_pend_ld  = w_redir;
          if (imem_ready_i) begin
            pc_d_o      = w_redir ? w_tgt : r_pend;
            pc_en_o     = 1'b1;
            w_state_nxt = FETCH;
          end
        end
        HOLD: begin
          instr_o       = r_skid.instr;
          instr_pc_o    = r_skid.pc;
          instr_valid_o = !stall_i && !w_redir;
          if (w_redir) begin
            pc_d_o      = w_tgt;
            pc_en_o     = 1'b1;
            w_state_nxt = FETCH;
          end else if (!stall_i) begin
            pc_d_o      = pc_next(pc_q_i);
            pc_en_o     = 1'b1;
            w_state_nxt = FETCH;
          end
        end
        default: begin
          w_state_nxt = BOOT;
        end
      endcase
    end
  end

  assign imem_addr_o = imem_req_o ? pc_q_i : '0;

`ifdef FETCH_PERF_EN
  // Free-running wrapping event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_o <= '0;
      perf_redir_o <= '0;
      perf_stall_o <= '0;
    end else begin
      if (instr_valid_o) begin
        perf_fetch_o <= XLEN'(perf_fetch_o + 1'b1);
      end
      if (w_redir) begin
        perf_redir_o <= XLEN'(perf_redir_o + 1'b1);
      end
      if (stall_i) begin
        perf_stall_o <= XLEN'(perf_stall_o + 1'b1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed vector table, reset-in-DRAIN sequence, random run vs. model.
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, exc_i, branch_taken_i, jump_i, imem_ready_i;
  logic [31:0] branch_target_i, jump_target_i, imem_rdata_i;
  logic [31:0] pc_q, pc_d_o, imem_addr_o, instr_o, instr_pc_o;
  logic        pc_en_o, imem_req_o, instr_valid_o;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_o, perf_redir_o, perf_stall_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(RST_PC), .EXC_VECTOR(EXC_VEC)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .exc_i(exc_i),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .jump_i(jump_i), .jump_target_i(jump_target_i), .pc_q_i(pc_q),
    .pc_d_o(pc_d_o), .pc_en_o(pc_en_o), .imem_req_o(imem_req_o),
    .imem_addr_o(imem_addr_o), .imem_ready_i(imem_ready_i),
    .imem_rdata_i(imem_rdata_i), .instr_valid_o(instr_valid_o),
    .instr_o(instr_o), .instr_pc_o(instr_pc_o)
`ifdef FETCH_PERF_EN
    , .perf_fetch_o(perf_fetch_o), .perf_redir_o(perf_redir_o), .perf_stall_o(perf_stall_o)
`endif
  );

  // External pc register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= '0;
    else if (pc_en_o) pc_q <= pc_d_o;
  end

  typedef struct {
    logic        stall, exc, br;
    logic [31:0] bt;
    logic        jmp;
    logic [31:0] jt;
    logic        rdy;
    logic        e_en;
    logic [31:0] e_d;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_ipc;
  } vec_t;

  vec_t vecs[$];

  // Reference-model state: booted, flushing a stale response, parked instruction PCs
  bit          m_booted;
  bit          m_flush;
  logic [31:0] m_pend;
  logic [31:0] m_pc;
  logic [31:0] m_held[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic vec_t mk(input logic s, input logic e, input logic b, input logic [31:0] bt,
                              input logic j, input logic [31:0] jt, input logic r,
                              input logic en, input logic [31:0] d, input logic rq,
                              input logic [31:0] a, input logic vl, input logic [31:0] ip);
    vec_t v;
    v.stall = s; v.exc = e; v.br = b; v.bt = bt; v.jmp = j; v.jt = jt; v.rdy = r;
    v.e_en = en; v.e_d = d; v.e_req = rq; v.e_addr = a; v.e_valid = vl; v.e_ipc = ip;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called right after a falling edge; leaves the bench at the next falling edge
  task automatic apply(input vec_t v, input string tag);
    stall_i = v.stall; exc_i = v.exc; branch_taken_i = v.br; branch_target_i = v.bt;
    jump_i = v.jmp; jump_target_i = v.jt; imem_ready_i = v.rdy;
    #1;
    imem_rdata_i = mem_word(imem_addr_o);
    #1;
    chk({tag, " pc_en"}, 32'(pc_en_o), 32'(v.e_en));
    chk({tag, " req"}, 32'(imem_req_o), 32'(v.e_req));
    chk({tag, " valid"}, 32'(instr_valid_o), 32'(v.e_valid));
    if (v.e_en)    chk({tag, " pc_d"}, pc_d_o, v.e_d);
    if (v.e_req)   chk({tag, " addr"}, imem_addr_o, v.e_addr);
    if (v.e_valid) begin
      chk({tag, " instr_pc"}, instr_pc_o, v.e_ipc);
      chk({tag, " instr"}, instr_o, mem_word(v.e_ipc));
    end
    @(negedge clk);
  endtask

  // Asynchronous reset: outputs must drop at once, BOOT follows release
  task automatic do_reset(input string tag);
    rst = 1'b1;
    stall_i = 0; exc_i = 0; branch_taken_i = 0; jump_i = 0; imem_ready_i = 1;
    branch_target_i = 0; jump_target_i = 0;
    #1;
    chk({tag, " rst pc_en"}, 32'(pc_en_o), 32'd0);
    chk({tag, " rst pc_d"}, pc_d_o, 32'd0);
    chk({tag, " rst req"}, 32'(imem_req_o), 32'd0);
    chk({tag, " rst addr"}, imem_addr_o, 32'd0);
    chk({tag, " rst valid"}, 32'(instr_valid_o), 32'd0);
    chk({tag, " rst instr"}, instr_o, 32'd0);
    chk({tag, " rst instr_pc"}, instr_pc_o, 32'd0);
`ifdef FETCH_PERF_EN
    @(posedge clk);
    #1;
    chk({tag, " rst perf_fetch"}, perf_fetch_o, 32'd0);
    chk({tag, " rst perf_redir"}, perf_redir_o, 32'd0);
    chk({tag, " rst perf_stall"}, perf_stall_o, 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_booted = 0; m_flush = 0; m_pend = '0; m_pc = '0; m_held.delete();
  endtask

  // Fill expected fields from the fetch rules
  task automatic model_step(inout vec_t v);
    logic        redir;
    logic [31:0] tgt;
    redir = v.exc | v.br | v.jmp;
    tgt   = v.exc ? EXC_VEC : (v.br ? v.bt : (v.jmp ? v.jt : 32'd0));
    v.e_en = 0; v.e_d = 0; v.e_req = 0; v.e_addr = 0; v.e_valid = 0; v.e_ipc = 0;
    if (!m_booted) begin
      v.e_en = 1; v.e_d = RST_PC; m_booted = 1;
    end else if (m_held.size() != 0) begin
      if (redir) begin
        v.e_en = 1; v.e_d = tgt; m_held.delete();
      end else if (!v.stall) begin
        v.e_valid = 1; v.e_ipc = m_held[0];
        v.e_en = 1; v.e_d = m_pc + 32'd4; m_held.delete();
      end
    end else begin
      v.e_req = 1; v.e_addr = m_pc;
      if (m_flush) begin
        if (redir) m_pend = tgt;
        if (v.rdy) begin
          v.e_en = 1; v.e_d = m_pend; m_flush = 0;
        end
      end else if (v.rdy) begin
        if (redir) begin
          v.e_en = 1; v.e_d = tgt;
        end else if (!v.stall) begin
          v.e_valid = 1; v.e_ipc = m_pc; v.e_en = 1; v.e_d = m_pc + 32'd4;
        end else begin
          m_held.push_back(m_pc);
        end
      end else if (redir) begin
        m_flush = 1; m_pend = tgt;
      end
    end
    if (v.e_en) m_pc = v.e_d;
  endtask

  initial begin
    vec_t        v;
    logic [31:0] r1, r2;
    rst = 1'b1;
    stall_i = 0; exc_i = 0; branch_taken_i = 0; jump_i = 0; imem_ready_i = 0;
    branch_target_i = 0; jump_target_i = 0; imem_rdata_i = 0;

    //           st ex br bt           jp jt           rd   en d             rq addr          vl ipc
    vecs.push_back(mk(0,0,0,0,         0,0,            1,   1,32'h0,         0,32'h0,         0,32'h0));
    vecs.push_back(mk(0,0,0,0,         0,0,            1,   1,32'h4,         1,32'h0,         1,32'h0));
    vecs.push_back(mk(0,0,0,0,         0,0,            1,   1,32'h8,         1,32'h4,         1,32'h4));
    vecs.push_back(mk(0,0,0,0,         0,0,            1,   1,32'hC,         1,32'h8,         1,32'h8));
    vecs.push_back(mk(0,0,0,0,         0,0,            1,   1,32'h10,        1,32'hC,         1,32'hC));
    vecs.push_back(mk(0,0,0,0,         0,0,            0,   0,32'h0,         1,32'h10,        0,32'h0));
    vecs.push_back(mk(0,0,0,0,         0,0,            0,   0,32'h0,         1,32'h10,        0,32'h0));
    vecs.push_back(mk(0,0,0,0,         0,0,            0,   0,32'h0,         1,32'h10,        0,32'h0));
    vecs.push_back(mk(0,0,0,0,         0,0,            1,   1,32'h14,        1,32'h10,        1,32'h10));
    vecs.push_back(mk(0,0,0,0,         0,0,            1,   1,32'h18,        1,32'h14,        1,32'h14));
    vecs.push_back(mk(0,0,0,0,         0,0,            1,   1,32'h1C,        1,32'h18,        1,32'h18));
    vecs.push_back(mk(0,0,0,0,         0,0,            1,   1,32'h20,        1,32'h1C,        1,32'h1C));
    vecs.push_back(mk(1,0,0,0,         0,0,            1,   0,32'h0,         1,32'h20,        0,32'h0));
    vecs.push_back(mk(1,0,0,0,         0,0,            1,   0,32'h0,         0,32'h0,         0,32'h0));
    vecs.push_back(mk(1,0,0,0,         0,0,            1,   0,32'h0,         0,32'h0,         0,32'h0));
    vecs.push_back(mk(0,0,0,0,         0,0,            1,   1,32'h24,        0,32'h0,         1,32'h20));
    vecs.push_back(mk(0,0,0,0,         0,0,            1,   1,32'h28,        1,32'h24,        1,32'h24));
    vecs.push_back(mk(1,0,1,32'h100,   1,32'h200,      1,   1,32'h100,       1,32'h28,        0,32'h0));
    vecs.push_back(mk(0,0,0,0,         0,0,            1,   1,32'h104,       1,32'h100,       1,32'h100));
    vecs.push_back(mk(0,0,0,0,         1,32'h40,       1,   1,32'h40,        1,32'h104,       0,32'h0));
    vecs.push_back(mk(0,1,0,0,         0,0,            0,   0,32'h0,         1,32'h40,        0,32'h0));
    vecs.push_back(mk(0,0,0,0,         0,0,            0,   0,32'h0,         1,32'h40,        0,32'h0));
    vecs.push_back(mk(0,0,0,0,         0,0,            1,   1,32'h80,        1,32'h40,        0,32'h0));
    vecs.push_back(mk(0,0,0,0,         1,32'hFFFFFFFC, 1,   1,32'hFFFFFFFC,  1,32'h80,        0,32'h0));
    vecs.push_back(mk(0,0,0,0,         0,0,            1,   1,32'h0,         1,32'hFFFFFFFC,  1,32'hFFFFFFFC));
    vecs.push_back(mk(0,0,0,0,         0,0,            1,   1,32'h4,         1,32'h0,         1,32'h0));
    vecs.push_back(mk(1,0,0,0,         0,0,            1,   0,32'h0,         1,32'h4,         0,32'h0));
    vecs.push_back(mk(0,1,0,0,         0,0,            1,   1,32'h80,        0,32'h0,         0,32'h0));
    vecs.push_back(mk(0,0,0,0,         0,0,            1,   1,32'h84,        1,32'h80,        1,32'h80));
    vecs.push_back(mk(0,0,1,32'h200,   0,0,            0,   0,32'h0,         1,32'h84,        0,32'h0));

    @(negedge clk);
    do_reset("init");
    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Now in DRAIN: reset drops the pending response and restarts at RESET_PC
    do_reset("drain");
    apply(mk(0,0,0,0, 0,0, 1,  1,RST_PC,        0,32'h0,  0,32'h0), "restart boot");
    apply(mk(0,0,0,0, 0,0, 1,  1,RST_PC + 32'd4, 1,RST_PC, 1,RST_PC), "restart fetch");
    apply(mk(0,0,0,0, 0,0, 1,  1,RST_PC + 32'd8, 1,RST_PC + 32'd4, 1,RST_PC + 32'd4), "restart fetch2");

    // Randomized run against the model
    do_reset("rand");
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset($sformatf("rand%0d", c));
      end
      r1 = $urandom();
      r2 = $urandom();
      v.stall = ($urandom_range(0, 3) == 0);
      v.exc   = ($urandom_range(0, 19) == 0);
      v.br    = ($urandom_range(0, 9) == 0);
      v.jmp   = ($urandom_range(0, 9) == 0);
      v.bt    = r1 & 32'hFFFF_FFFC;
      v.jt    = r2 & 32'hFFFF_FFFC;
      v.rdy   = ($urandom_range(0, 7) < 5);
      model_step(v);
      apply(v, $sformatf("rand%0d", c));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
